instruction_decode_buffer: RTL and testbench

INSTRUCTION_DECODE_BUFFER -- requirements
Module: instruction_decode_buffer

---
 rtl/instruction_decode_buffer.sv | 111 +++++++++++
 tb/tb_instruction_decode_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_buffer.sv
// Two-entry in-order buffer between fetch and decode.
// Pre-decodes immediate format and opcode legality at push time.
module instruction_decode_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetchValid,
  input  logic [31:0] fetchInstruction,
  input  logic [31:0] fetchPc,
  output logic        fetchReady,
  input  logic        flush,
  output logic        decodeValid,
  output logic [31:0] decodeInstruction,
  output logic [31:0] decodePc,
  output logic [2:0]  immediateSelect,
  output logic        illegalOpcode,
  input  logic        decodeReady
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_sel;
    logic        illegal;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  entry_t      mem_q [2];
  logic [1:0]  count_q;
  logic        wptr_q;
  logic        rptr_q;
  logic        push;
  logic        pop;
  entry_t      new_e;
  entry_t      head;
  logic [6:0]  op;

  assign fetchReady  = (count_q != 2'd2);
  assign decodeValid = (count_q != 2'd0);

  assign push = fetchValid & fetchReady & ~flush;
  assign pop  = decodeValid & decodeReady & ~flush;

  assign op = fetchInstruction[6:0];

  // Any opcode outside the table, including low bits != 11, is illegal.
  always_comb begin
    new_e.instr   = fetchInstruction;
    new_e.pc      = fetchPc;
    new_e.imm_sel = 3'b111;
    new_e.illegal = 1'b0;
    unique case (1'b1)
      (op == 7'b0110111),
      (op == 7'b0010111): new_e.imm_sel = 3'b000;
      (op == 7'b1101111): new_e.imm_sel = 3'b001;
      (op == 7'b0010011),
      (op == 7'b0000011),
      (op == 7'b1100111),
      (op == 7'b1110011): new_e.imm_sel = 3'b010;
      (op == 7'b1100011): new_e.imm_sel = 3'b011;
      (op == 7'b0100011): new_e.imm_sel = 3'b100;
      (op == 7'b0110011),
      (op == 7'b0001111): new_e.imm_sel = 3'b111;
      default: begin
        new_e.imm_sel = 3'b111;
        new_e.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else if (flush) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never cleared; empty-state outputs hide stale data.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wptr_q] <= new_e;
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    decodeInstruction = NOP;
    decodePc          = 32'd0;
    immediateSelect   = 3'b010;
    illegalOpcode     = 1'b0;
    if (decodeValid) begin
      decodeInstruction = head.instr;
      decodePc          = head.pc;
      immediateSelect   = head.imm_sel;
      illegalOpcode     = head.illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode_buffer.sv
// Directed bench for instruction_decode_buffer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instruction_decode_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [31:0] fetchPc;
  logic        fetchReady;
  logic        flush;
  logic        decodeValid;
  logic [31:0] decodeInstruction;
  logic [31:0] decodePc;
  logic [2:0]  immediateSelect;
  logic        illegalOpcode;
  logic        decodeReady;

  int tests = 0;
  int fails = 0;

  instruction_decode_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetchValid(fetchValid),
    .fetchInstruction(fetchInstruction),
    .fetchPc(fetchPc),
    .fetchReady(fetchReady),
    .flush(flush),
    .decodeValid(decodeValid),
    .decodeInstruction(decodeInstruction),
    .decodePc(decodePc),
    .immediateSelect(immediateSelect),
    .illegalOpcode(illegalOpcode),
    .decodeReady(decodeReady)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(decodeValid), 32'd0);
    chk({tag, "_ready"}, 32'(fetchReady), 32'd1);
    chk({tag, "_instr"}, decodeInstruction, 32'h13);
    chk({tag, "_pc"}, decodePc, 32'd0);
    chk({tag, "_sel"}, 32'(immediateSelect), 32'd2);
    chk({tag, "_ill"}, 32'(illegalOpcode), 32'd0);
  endtask

  task automatic chk_head(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] pc,
                          input logic [2:0] sel,
                          input logic ill);
    chk({tag, "_valid"}, 32'(decodeValid), 32'd1);
    chk({tag, "_instr"}, decodeInstruction, ins);
    chk({tag, "_pc"}, decodePc, pc);
    chk({tag, "_sel"}, 32'(immediateSelect), 32'(sel));
    chk({tag, "_ill"}, 32'(illegalOpcode), 32'(ill));
  endtask

  task automatic offer(input logic [31:0] ins,
                       input logic [31:0] pc);
    fetchValid       = 1'b1;
    fetchInstruction = ins;
    fetchPc          = pc;
  endtask

  task automatic push1(input logic [31:0] ins,
                       input logic [31:0] pc);
    offer(ins, pc);
    step();
    fetchValid = 1'b0;
  endtask

  task automatic pop1();
    decodeReady = 1'b1;
    step();
    decodeReady = 1'b0;
  endtask

  logic [31:0] dec_ins [10];
  logic [2:0]  dec_sel [10];
  logic        dec_ill [10];
  logic [31:0] exp_ins;

  initial begin
    rst_n            = 1'b0;
    fetchValid       = 1'b0;
    fetchInstruction = 32'd0;
    fetchPc          = 32'd0;
    flush            = 1'b0;
    decodeReady      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_empty("reset");

    // single pass-through, no bypass
    offer(32'h123450B7, 32'h100);
    chk("lui_nobypass", 32'(decodeValid), 32'd0);
    step();
    fetchValid = 1'b0;
    chk_head("lui", 32'h123450B7, 32'h100, 3'b000, 1'b0);
    pop1();
    chk_empty("lui_drain");

    // backpressure
    push1(32'h00A00093, 32'h200);
    push1(32'hFE000EE3, 32'h204);
    chk("bp_full_ready", 32'(fetchReady), 32'd0);
    chk_head("bp_head0", 32'h00A00093, 32'h200, 3'b010, 1'b0);
    push1(32'h00000033, 32'h208);
    chk("bp_third_ready", 32'(fetchReady), 32'd0);
    chk_head("bp_hold", 32'h00A00093, 32'h200, 3'b010, 1'b0);
    pop1();
    chk("bp_ready_after_pop", 32'(fetchReady), 32'd1);
    chk_head("bp_head1", 32'hFE000EE3, 32'h204, 3'b011, 1'b0);
    pop1();
    chk_empty("bp_third_dropped");

    // back-to-back push/pop at count 1
    push1(32'h00000013, 32'h300);
    for (int i = 1; i <= 10; i++) begin
      offer(32'h00000013 | (32'(i) << 20), 32'h300 + 32'(4 * i));
      decodeReady = 1'b1;
      exp_ins = 32'h00000013 | (32'(i - 1) << 20);
      chk($sformatf("stream_ins%0d", i), decodeInstruction, exp_ins);
      chk($sformatf("stream_pc%0d", i), decodePc,
          32'h300 + 32'(4 * (i - 1)));
      chk($sformatf("stream_rdy%0d", i), 32'(fetchReady), 32'd1);
      step();
    end
    fetchValid  = 1'b0;
    decodeReady = 1'b0;
    chk_head("stream_last", 32'h00A00013, 32'h328, 3'b010, 1'b0);
    pop1();
    chk_empty("stream_drain");

    // flush with two entries and a live offer
    push1(32'h00100093, 32'h400);
    push1(32'h00200093, 32'h404);
    offer(32'h00500113, 32'h500);
    decodeReady = 1'b1;
    flush       = 1'b1;
    step();
    flush       = 1'b0;
    fetchValid  = 1'b0;
    decodeReady = 1'b0;
    chk_empty("flush");
    step();
    chk_empty("flush_no_ghost");
    push1(32'h0000006F, 32'h440);
    chk_head("after_flush", 32'h0000006F, 32'h440, 3'b001, 1'b0);
    pop1();

    // illegal opcodes
    push1(32'hFFFFFFFF, 32'h600);
    push1(32'h00000000, 32'h604);
    chk_head("ill_ff", 32'hFFFFFFFF, 32'h600, 3'b111, 1'b1);
    pop1();
    chk_head("ill_00", 32'h00000000, 32'h604, 3'b111, 1'b1);
    pop1();

    // opcode decode table
    dec_ins[0] = 32'h00000017; dec_sel[0] = 3'b000; dec_ill[0] = 1'b0;
    dec_ins[1] = 32'h00000067; dec_sel[1] = 3'b010; dec_ill[1] = 1'b0;
    dec_ins[2] = 32'h00000073; dec_sel[2] = 3'b010; dec_ill[2] = 1'b0;
    dec_ins[3] = 32'h00000003; dec_sel[3] = 3'b010; dec_ill[3] = 1'b0;
    dec_ins[4] = 32'h0000000F; dec_sel[4] = 3'b111; dec_ill[4] = 1'b0;
    dec_ins[5] = 32'h00000033; dec_sel[5] = 3'b111; dec_ill[5] = 1'b0;
    dec_ins[6] = 32'h00000023; dec_sel[6] = 3'b100; dec_ill[6] = 1'b0;
    dec_ins[7] = 32'h0000007F; dec_sel[7] = 3'b111; dec_ill[7] = 1'b1;
    dec_ins[8] = 32'h00000011; dec_sel[8] = 3'b111; dec_ill[8] = 1'b1;
    dec_ins[9] = 32'h00000037; dec_sel[9] = 3'b000; dec_ill[9] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push1(dec_ins[i], 32'h800 + 32'(4 * i));
      chk($sformatf("dec_sel%0d", i), 32'(immediateSelect),
          32'(dec_sel[i]));
      chk($sformatf("dec_ill%0d", i), 32'(illegalOpcode),
          32'(dec_ill[i]));
      pop1();
    end

    // reset mid-operation at count 2
    push1(32'h00300093, 32'h900);
    push1(32'h00400093, 32'h904);
    offer(32'h00500093, 32'h908);
    decodeReady = 1'b1;
    rst_n       = 1'b0;
    step();
    rst_n       = 1'b1;
    fetchValid  = 1'b0;
    decodeReady = 1'b0;
    chk_empty("rst_mid");
    push1(32'h00112223, 32'hA00);
    chk_head("rst_stype", 32'h00112223, 32'hA00, 3'b100, 1'b0);
    pop1();
    chk_empty("rst_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
